// File: rtl/id_ex_stage_buf.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer.
// in_ready is registered so no combinational path runs from out_ready back to decode.
module id_ex_stage_buf #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [21:0]     in_ctrl,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [21:0]     out_ctrl,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [1:0]      occupancy
);

    // state    | meaning
    // ST_EMPTY | no entry held
    // ST_ONE   | main entry valid, skid empty
    // ST_TWO   | main and skid entries valid, decode stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [21:0]     ctrl;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } entry_t;

    state_t state_q, state_d;
    logic   in_ready_q;
    entry_t main_q, skid_q, in_entry;
    logic   load_main, main_from_skid, load_skid;
    logic   accept, retire;

    assign in_entry = '{ctrl: in_ctrl, pc: in_pc, inst: in_inst,
                        rs1: in_rs1_data, rs2: in_rs2_data, imm: in_imm};

    assign accept = in_valid & in_ready_q;
    assign retire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // Flush wins: the state returns to empty and nothing is loaded, so a
    // same-cycle accept is dropped while a same-cycle retire still completes.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (retire && accept) begin
                        load_main = 1'b1;
                    end else if (retire) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (retire) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload registers are not cleared by flush; only valid state is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_entry;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign occupancy    = state_q;

    // we_reg/we_mem/npc_sel must never look live on an empty stage.
    assign out_ctrl     = {main_q.ctrl[21:19] & {3{out_valid}}, main_q.ctrl[18:0]};
    assign out_pc       = main_q.pc;
    assign out_inst     = main_q.inst;
    assign out_rs1_data = main_q.rs1;
    assign out_rs2_data = main_q.rs2;
    assign out_imm      = main_q.imm;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed and randomized checks of id_ex_stage_buf against hand-computed values and a queue model.
module tb_id_ex_stage_buf;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [21:0]     in_ctrl;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [21:0]     out_ctrl;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [1:0]      occupancy;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage_buf #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_inst(in_inst),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Payload fields derived from the PC so each entry is self-identifying.
    task automatic drive(input logic v, input logic [63:0] pc);
        in_valid    = v;
        in_pc       = pc;
        in_inst     = pc[31:0] ^ 32'hA5A5_5A5A;
        in_rs1_data = pc + 64'h1111;
        in_rs2_data = ~pc;
        in_imm      = {pc[31:0], pc[31:0]};
        in_ctrl     = 22'h3F_FFFF;
    endtask

    logic [63:0] q[$];
    logic [63:0] next_pc;
    logic        acc, ret, exp_ready, exp_valid;
    logic [21:0] lui_ctrl;

    initial begin
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i));
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_pc", out_pc, 64'h1000 + 64'(4 * i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, 64'h0);
        step();
        chk("stream_drain", 64'(out_valid), 64'd0);

        // backpressure fills both entries
        out_ready = 1'b0;
        drive(1'b1, 64'h3000);
        step();
        drive(1'b1, 64'h3004);
        step();
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_ready0", 64'(in_ready), 64'd0);
        chk("bp_head", out_pc, 64'h3000);
        drive(1'b0, 64'h0);
        out_ready = 1'b1;
        step();
        chk("bp_ready1", 64'(in_ready), 64'd1);
        chk("bp_second", out_pc, 64'h3004);
        chk("bp_second_inst", 64'(out_inst), 64'(32'h3004 ^ 32'hA5A5_5A5A));
        chk("bp_occ1", 64'(occupancy), 64'd1);
        step();
        chk("bp_occ0", 64'(occupancy), 64'd0);

        // flush while full, with a concurrent accept attempt
        out_ready = 1'b0;
        drive(1'b1, 64'h4000);
        step();
        drive(1'b1, 64'h4004);
        step();
        chk("fl_occ2", 64'(occupancy), 64'd2);
        flush = 1'b1;
        drive(1'b1, 64'h2000);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_gate", 64'(out_ctrl[21:19]), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        step();
        chk("fl_still_empty", 64'(out_valid), 64'd0);
        chk("fl_pc_held", out_pc, 64'h4000);

        // LUI bundle passes through bit-exact
        lui_ctrl = 22'b1_0_0_100_0000_000_00_10_01_000;
        drive(1'b1, 64'h6000);
        in_ctrl = lui_ctrl;
        in_imm  = 64'h1234_5000;
        step();
        chk("lui_ctrl", 64'(out_ctrl), 64'(lui_ctrl));
        chk("lui_imm", out_imm, 64'h1234_5000);
        chk("lui_rs2", out_rs2_data, ~64'h6000);
        drive(1'b0, 64'h0);
        out_ready = 1'b1;
        step();
        chk("lui_gated", 64'(out_ctrl), 64'(lui_ctrl & 22'h07_FFFF));

        // async reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, 64'h7000);
        step();
        drive(1'b1, 64'h7004);
        step();
        drive(1'b0, 64'h0);
        chk("ar_occ2", 64'(occupancy), 64'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_pc", out_pc, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        drive(1'b1, 64'h5000);
        step();
        drive(1'b0, 64'h0);
        chk("ar_first_valid", 64'(out_valid), 64'd1);
        chk("ar_first_pc", out_pc, 64'h5000);
        chk("ar_first_occ", 64'(occupancy), 64'd1);
        out_ready = 1'b1;
        step();

        // randomized traffic against a queue model
        q.delete();
        next_pc = 64'h10_0000;
        for (int c = 0; c < 4000; c++) begin
            exp_ready = (q.size() < 2);
            exp_valid = (q.size() > 0);
            chk("rnd_ready", 64'(in_ready), 64'(exp_ready));
            chk("rnd_valid", 64'(out_valid), 64'(exp_valid));
            chk("rnd_occ", 64'(occupancy), 64'(q.size()));
            if (exp_valid) begin
                chk("rnd_pc", out_pc, q[0]);
                chk("rnd_inst", 64'(out_inst), 64'(q[0][31:0] ^ 32'hA5A5_5A5A));
                chk("rnd_rs1", out_rs1_data, q[0] + 64'h1111);
            end
            drive(1'($urandom_range(0, 3) != 0), next_pc);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            acc = in_valid && exp_ready;
            ret = exp_valid && out_ready;
            step();
            if (ret) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(next_pc);
            if (acc) next_pc = next_pc + 64'd4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
